// File: rtl/sampler_pkg.sv
// Shared defaults and FSM state encoding for the stereo sample reader.
package sampler_pkg;

    localparam int unsigned DEFAULT_ADDR_W    = 15;
    localparam int unsigned DEFAULT_DATA_W    = 16;
    localparam int unsigned DEFAULT_LAST_ADDR = 'h72D7;

    typedef enum logic [2:0] {
        StIdle,
        StRdL,
        StRdR,
        StCapR,
        StPresent,
        StDone
    } state_e;

endpackage

// File: rtl/pair_base_counter.sv
// Even base address of the current left/right pair: steps by 2 and wraps to 0 after LAST_ADDR.
module pair_base_counter #(
    parameter int unsigned        ADDR_W    = 15,
    parameter logic [ADDR_W-1:0] LAST_ADDR = 15'h72D7
) (
    input  logic              clk_i,
    input  logic              clear_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] base_o,
    output logic [ADDR_W-1:0] next_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] base_q, base_d;

    always_comb begin
        last_o = (base_q + ADDR_W'(1)) == LAST_ADDR;
        next_o = last_o ? '0 : base_q + ADDR_W'(2);
        base_d = step_i ? next_o : base_q;
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            base_q <= '0;
        end else begin
            base_q <= base_d;
        end
    end

    assign base_o = base_q;

endmodule

// File: rtl/stereo_sample_reader.sv
// Reads interleaved left/right sample pairs from memory and presents them with a valid/ready handshake.
// Define LOOP_PLAYBACK_EN to wrap to address 0 after the last pair instead of stopping in DONE.
module stereo_sample_reader
    import sampler_pkg::*;
#(
    parameter int unsigned        ADDR_W    = DEFAULT_ADDR_W,
    parameter int unsigned        DATA_W    = DEFAULT_DATA_W,
    parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEFAULT_LAST_ADDR)
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              EN,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] left_out,
    output logic [DATA_W-1:0] right_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done
);

`ifdef LOOP_PLAYBACK_EN
    localparam bit LoopEn = 1'b1;
`else
    localparam bit LoopEn = 1'b0;
`endif

    state_e            state_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_rd_q;
    logic [DATA_W-1:0] left_q, right_q;
    logic              out_valid_q;
    logic              done_q;

    logic [ADDR_W-1:0] base, base_next;
    logic              base_last;
    logic              handshake;
    logic              base_step;

    assign handshake = (state_q == StPresent) && out_ready;
    // Without looping the base stays on the last pair once playback has finished.
    assign base_step = handshake && (LoopEn || !base_last);

    pair_base_counter #(
        .ADDR_W   (ADDR_W),
        .LAST_ADDR(LAST_ADDR)
    ) u_base (
        .clk_i  (clk),
        .clear_i(clear),
        .step_i (base_step),
        .base_o (base),
        .next_o (base_next),
        .last_o (base_last)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= StIdle;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            if (LoopEn) begin
                done_q <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (EN) begin
                        state_q    <= StRdL;
                        mem_addr_q <= base;
                        mem_rd_q   <= 1'b1;
                    end
                end
                StRdL: begin
                    state_q    <= StRdR;
                    mem_addr_q <= base + ADDR_W'(1);
                    mem_rd_q   <= 1'b1;
                end
                StRdR: begin
                    state_q  <= StCapR;
                    left_q   <= mem_rdata;
                    mem_rd_q <= 1'b0;
                end
                StCapR: begin
                    state_q     <= StPresent;
                    right_q     <= mem_rdata;
                    out_valid_q <= 1'b1;
                end
                StPresent: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (base_last) begin
                            done_q <= 1'b1;
                        end
                        if (base_last && !LoopEn) begin
                            state_q <= StDone;
                        end else if (EN) begin
                            state_q    <= StRdL;
                            mem_addr_q <= base_next;
                            mem_rd_q   <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StDone: begin
                    mem_rd_q <= 1'b0;
                    done_q   <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign left_out  = left_q;
    assign right_out = right_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_stereo_sample_reader.sv
// Directed bench for stereo_sample_reader; memory word equals its address.
module tb_stereo_sample_reader;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;
    localparam int NPAIRS = 14700;

    logic              clk = 1'b0;
    logic              clear = 1'b0;
    logic              EN = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [DATA_W-1:0] left_out, right_out;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              done;

    int n_cmp = 0;
    int n_err = 0;

    stereo_sample_reader dut (
        .clk      (clk),
        .clear    (clear),
        .EN       (EN),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_rdata(mem_rdata),
        .left_out (left_out),
        .right_out(right_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= {1'b0, mem_addr};
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_clear;
        clear = 1'b1; EN = 1'b0; out_ready = 1'b0;
        tick();
        clear = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL wait_valid: out_valid got %b want 1 within 16 cycles", out_valid);
        end
    endtask

    task automatic test_reset;
        clear = 1'b1; EN = 1'b1; out_ready = 1'b1;
        tick();
        tick();
        n_cmp++; if (mem_addr !== '0) begin n_err++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        n_cmp++; if (mem_rd !== 1'b0) begin n_err++; $display("FAIL reset_rd: got %b want 0", mem_rd); end
        n_cmp++; if (left_out !== '0) begin n_err++; $display("FAIL reset_left: got %h want 0", left_out); end
        n_cmp++; if (right_out !== '0) begin n_err++; $display("FAIL reset_right: got %h want 0", right_out); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        clear = 1'b0; EN = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_basic;
        do_clear();
        EN = 1'b1; out_ready = 1'b1;
        tick(); // n+1: RD_L
        n_cmp++; if ({mem_rd, mem_addr, out_valid} !== {1'b1, 15'h0, 1'b0}) begin
            n_err++; $display("FAIL basic_rdl: rd/addr/valid got %b/%h/%b want 1/0000/0", mem_rd, mem_addr, out_valid); end
        tick(); // n+2: RD_R
        n_cmp++; if ({mem_rd, mem_addr} !== {1'b1, 15'h1}) begin
            n_err++; $display("FAIL basic_rdr: rd/addr got %b/%h want 1/0001", mem_rd, mem_addr); end
        tick(); // n+3: CAP_R
        n_cmp++; if ({mem_rd, out_valid} !== 2'b00) begin
            n_err++; $display("FAIL basic_capr: rd/valid got %b/%b want 0/0", mem_rd, out_valid); end
        tick(); // n+4: PRESENT
        n_cmp++; if ({out_valid, left_out, right_out} !== {1'b1, 16'h0000, 16'h0001}) begin
            n_err++; $display("FAIL basic_pair0: valid/left/right got %b/%h/%h want 1/0000/0001", out_valid, left_out, right_out); end
        tick();
        n_cmp++; if ({out_valid, mem_rd, mem_addr} !== {1'b0, 1'b1, 15'h2}) begin
            n_err++; $display("FAIL basic_next: valid/rd/addr got %b/%b/%h want 0/1/0002", out_valid, mem_rd, mem_addr); end
        tick(); tick(); tick();
        n_cmp++; if ({out_valid, left_out, right_out} !== {1'b1, 16'h0002, 16'h0003}) begin
            n_err++; $display("FAIL basic_pair1: valid/left/right got %b/%h/%h want 1/0002/0003", out_valid, left_out, right_out); end
        EN = 1'b0;
        tick();
        n_cmp++; if ({out_valid, done} !== 2'b00) begin
            n_err++; $display("FAIL basic_drop: valid/done got %b/%b want 0/0", out_valid, done); end
    endtask

    task automatic test_backpressure;
        do_clear();
        EN = 1'b1; out_ready = 1'b0;
        tick(); tick(); tick(); tick();
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if ({out_valid, left_out, right_out, mem_rd} !== {1'b1, 16'h0000, 16'h0001, 1'b0}) begin
                n_err++; $display("FAIL bp_hold%0d: valid/left/right/rd got %b/%h/%h/%b want 1/0000/0001/0", i, out_valid, left_out, right_out, mem_rd); end
            tick();
        end
        out_ready = 1'b1;
        tick();
        n_cmp++; if ({out_valid, mem_rd, mem_addr} !== {1'b0, 1'b1, 15'h2}) begin
            n_err++; $display("FAIL bp_release: valid/rd/addr got %b/%b/%h want 0/1/0002", out_valid, mem_rd, mem_addr); end
    endtask

    task automatic test_pause;
        bit ok;
        bit idle_bad;
        do_clear();
        EN = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_valid(ok);
            n_cmp++; if ({left_out, right_out} !== {16'(2 * k), 16'(2 * k + 1)}) begin
                n_err++; $display("FAIL pause_pair%0d: left/right got %h/%h want %h/%h", k, left_out, right_out, 16'(2 * k), 16'(2 * k + 1)); end
            if (k == 5) EN = 1'b0;
            tick();
        end
        idle_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (mem_rd !== 1'b0 || out_valid !== 1'b0) idle_bad = 1'b1;
            tick();
        end
        n_cmp++; if (idle_bad) begin n_err++; $display("FAIL pause_idle: rd/valid got %b/%b want 0/0", mem_rd, out_valid); end
        EN = 1'b1;
        tick();
        n_cmp++; if ({mem_rd, mem_addr} !== {1'b1, 15'd12}) begin
            n_err++; $display("FAIL pause_resume_l: rd/addr got %b/%h want 1/000c", mem_rd, mem_addr); end
        tick();
        n_cmp++; if ({mem_rd, mem_addr} !== {1'b1, 15'd13}) begin
            n_err++; $display("FAIL pause_resume_r: rd/addr got %b/%h want 1/000d", mem_rd, mem_addr); end
        wait_valid(ok);
        n_cmp++; if ({left_out, right_out} !== {16'd12, 16'd13}) begin
            n_err++; $display("FAIL pause_pair6: left/right got %h/%h want 000c/000d", left_out, right_out); end
    endtask

    task automatic test_mid_reset;
        bit ok;
        do_clear();
        EN = 1'b1; out_ready = 1'b1;
        tick(); tick();
        n_cmp++; if ({mem_rd, mem_addr} !== {1'b1, 15'h1}) begin
            n_err++; $display("FAIL midrst_rdr: rd/addr got %b/%h want 1/0001", mem_rd, mem_addr); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_cmp++; if ({mem_addr, mem_rd, left_out, right_out, out_valid, done} !== '0) begin
            n_err++; $display("FAIL midrst_zero: addr/rd/left/right/valid/done got %h/%b/%h/%h/%b/%b want all 0",
                              mem_addr, mem_rd, left_out, right_out, out_valid, done); end
        tick();
        n_cmp++; if ({mem_rd, mem_addr} !== {1'b1, 15'h0}) begin
            n_err++; $display("FAIL midrst_restart: rd/addr got %b/%h want 1/0000", mem_rd, mem_addr); end
        wait_valid(ok);
        n_cmp++; if ({left_out, right_out} !== {16'h0000, 16'h0001}) begin
            n_err++; $display("FAIL midrst_pair0: left/right got %h/%h want 0000/0001", left_out, right_out); end
    endtask

    task automatic test_end;
        bit ok;
        bit tail_bad;
        int shown;
        shown = 0;
        do_clear();
        EN = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < NPAIRS; k++) begin
            wait_valid(ok);
            if (!ok) break;
            n_cmp++; if ({done, left_out, right_out} !== {1'b0, 16'(2 * k), 16'(2 * k + 1)}) begin
                n_err++;
                if (shown < 5) $display("FAIL end_pair%0d: done/left/right got %b/%h/%h want 0/%h/%h",
                                        k, done, left_out, right_out, 16'(2 * k), 16'(2 * k + 1));
                shown++;
            end
            if (k == NPAIRS - 1) begin
                n_cmp++; if ({left_out, right_out} !== {16'h72D6, 16'h72D7}) begin
                    n_err++; $display("FAIL end_last: left/right got %h/%h want 72d6/72d7", left_out, right_out); end
            end
            tick();
        end
`ifdef LOOP_PLAYBACK_EN
        n_cmp++; if ({done, out_valid, mem_rd, mem_addr} !== {1'b1, 1'b0, 1'b1, 15'h0}) begin
            n_err++; $display("FAIL loop_wrap: done/valid/rd/addr got %b/%b/%b/%h want 1/0/1/0000", done, out_valid, mem_rd, mem_addr); end
        tick();
        n_cmp++; if ({done, mem_rd, mem_addr} !== {1'b0, 1'b1, 15'h1}) begin
            n_err++; $display("FAIL loop_pulse: done/rd/addr got %b/%b/%h want 0/1/0001", done, mem_rd, mem_addr); end
        wait_valid(ok);
        n_cmp++; if ({left_out, right_out} !== {16'h0000, 16'h0001}) begin
            n_err++; $display("FAIL loop_pair0: left/right got %h/%h want 0000/0001", left_out, right_out); end
`else
        n_cmp++; if ({done, out_valid, mem_rd} !== {1'b1, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL end_done: done/valid/rd got %b/%b/%b want 1/0/0", done, out_valid, mem_rd); end
        tail_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_rd !== 1'b0 || done !== 1'b1 || out_valid !== 1'b0) tail_bad = 1'b1;
        end
        n_cmp++; if (tail_bad) begin
            n_err++; $display("FAIL end_hold: done/valid/rd got %b/%b/%b want 1/0/0 for 20 cycles", done, out_valid, mem_rd); end
`endif
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_pause();
        test_mid_reset();
        test_end();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stereo_sample_reader.md
STEREO_SAMPLE_READER -- requirements
Module: stereo_sample_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 15: sample memory address width.
REQ-002 SHALL have parameter DATA_W, default 16: sample word width.
REQ-003 SHALL have parameter LAST_ADDR, default 15'h72D7: highest (odd) address in the stored region.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on posedge.
REQ-005 SHALL have port clear, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port EN, input, 1: playback enable.
REQ-007 SHALL have port mem_addr, output, ADDR_W: read address.
REQ-008 SHALL have port mem_rd, output, 1: read strobe.
REQ-009 SHALL have port mem_rdata, input, DATA_W: read data, valid exactly 1 cycle after the cycle with mem_rd=1.
REQ-010 SHALL have port left_out, output, DATA_W: even-address sample of the current pair.
REQ-011 SHALL have port right_out, output, DATA_W: odd-address sample of the current pair.
REQ-012 SHALL have port out_valid, output, 1: pair available.
REQ-013 SHALL have port out_ready, input, 1: consumer accepts.
REQ-014 SHALL have port done, output, 1: end of region reached.

Function
REQ-015 Memory layout: left samples at even addresses 0..LAST_ADDR-1; right samples at odd addresses 1..LAST_ADDR; pair k = {2k, 2k+1}.
REQ-016 FSM states SHALL be IDLE, RD_L, RD_R, CAP_R, PRESENT, DONE.
REQ-017 IDLE: mem_rd=0; EN=1 -> RD_L; else stay.
REQ-018 RD_L: mem_addr=base (even), mem_rd=1 -> RD_R.
REQ-019 RD_R: left_out<=mem_rdata; mem_addr=base+1, mem_rd=1 -> CAP_R.
REQ-020 CAP_R: right_out<=mem_rdata; mem_rd=0 -> PRESENT.
REQ-021 PRESENT: out_valid=1; left_out/right_out held stable until out_valid&&out_ready.
REQ-022 Handshake SHALL complete in the cycle out_valid&&out_ready; out_valid SHALL drop the next cycle.
REQ-023 On handshake with base+1 != LAST_ADDR: base<=base+2; EN=1 -> RD_L, EN=0 -> IDLE (pause, base retained).
REQ-024 On handshake with base+1 == LAST_ADDR: end-of-region behaviour per REQ-031/REQ-032.
REQ-025 EN deasserted during RD_L/RD_R/CAP_R/PRESENT SHALL NOT abort the pair in flight.
REQ-026 Latency: EN sampled high in IDLE at cycle n -> out_valid=1 at cycle n+4.
REQ-027 mem_rd SHALL never be asserted outside RD_L/RD_R; base SHALL always be even and <= LAST_ADDR-1.

Reset
REQ-028 clear=1 at a clock edge SHALL force state=IDLE, base=0, mem_addr=0, mem_rd=0, left_out=0, right_out=0, out_valid=0, done=0, from any state including mid-pair.
REQ-029 clear SHALL take priority over EN and out_ready in the same cycle.

Configuration
REQ-030 Macro LOOP_PLAYBACK_EN SHALL select end-of-region behaviour.
REQ-031 Without LOOP_PLAYBACK_EN: last-pair handshake -> DONE; done=1 held; mem_rd=0; EN ignored; exit only via clear.
REQ-032 With LOOP_PLAYBACK_EN: last-pair handshake -> base<=0, done=1 for exactly 1 cycle, continue per REQ-023; DONE state unreachable.

Structure
REQ-033 Package sampler_pkg SHALL hold ADDR_W, DATA_W, LAST_ADDR defaults and the FSM state enum.
REQ-034 Sub-module pair_base_counter SHALL hold base (step 2, wrap/last flag, synchronous clear); the FSM and data registers SHALL live in stereo_sample_reader.

Verification
REQ-035 Basic: memory word = address value, EN=1, out_ready=1 -> first pair left=0x0000, right=0x0001, out_valid at cycle n+4; second pair 0x0002/0x0003.
REQ-036 Backpressure: out_ready=0 for 10 cycles in PRESENT -> out_valid and data stable, mem_rd=0, base unchanged.
REQ-037 Pause: EN=0 at handshake of pair 5 -> IDLE with base=12; EN=1 -> next reads at 12 and 13.
REQ-038 End without macro: run all 14700 pairs -> last pair 0x72D6/0x72D7, done=1 held, no further mem_rd.
REQ-039 End with LOOP_PLAYBACK_EN: after pair 0x72D6/0x72D7 -> done pulses 1 cycle, next read at address 0.
REQ-040 Reset mid-operation: clear=1 in RD_R -> next cycle all outputs 0, state IDLE; EN=1 -> restart at address 0.
